// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: multicycle issue/control sequencer sitting between instruction
// fetch and the ALU / register file. Accepts one 32-bit instruction per
// valid/ready handshake, sequences it through DECODE/EXEC/WB, owns the
// architectural {O,S,C,Z} flag register and the program counter.
//
// Optional feature: define ALU_CTRL_SIGNED_COND_EN to enable the signed jump
// conditions (9=LT, 10=GE, 11=LE, 12=GT). Without it, codes 9-15 never jump.
module alu_ctrl_seq #(
  parameter int          PC_W   = 16,
  parameter logic [15:0] RST_PC = 16'd0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [4:0]      alu_op,
  input  logic [31:0]     alu_res,
  input  logic            alu_o,
  input  logic            alu_s,
  input  logic            alu_c,
  output logic [4:0]      rf_ra,
  output logic [4:0]      rf_rb,
  output logic [4:0]      rf_wa,
  output logic [31:0]     rf_wd,
  output logic            rf_we,
  output logic [3:0]      flags,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [1:0] FMT_ALU  = 2'b00;
  localparam logic [1:0] FMT_LDI  = 2'b01;
  localparam logic [1:0] FMT_JMP  = 2'b10;
  localparam logic [1:0] FMT_HALT = 2'b11;

  state_t          state_q, state_d;
  logic [31:0]     ir_q;
  logic [PC_W-1:0] pc_q;
  logic [3:0]      flags_q;       // {O,S,C,Z} architectural flags
  logic [3:0]      flags_pend_q;  // flags captured in EXEC, committed in WB
  logic [4:0]      alu_op_q;
  logic [4:0]      rf_ra_q, rf_rb_q, rf_wa_q;
  logic [31:0]     rf_wd_q;
  logic            rf_we_q;
  logic            halted_q;

  logic [1:0]      fmt;
  logic [4:0]      rd;
  logic [31:0]     imm_sext;
  logic [PC_W-1:0] jmp_target;
  logic [PC_W-1:0] pc_inc;
  logic            jmp_taken;
  logic            ir_unused;

  assign fmt        = ir_q[31:30];
  assign rd         = ir_q[24:20];
  assign imm_sext   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign jmp_target = ir_q[PC_W-1:0];
  assign pc_inc     = pc_q + PC_W'(1);
  // ra/rb/op are taken from the instruction word at capture so they are
  // already valid during DECODE; these IR bits are therefore not read back.
  assign ir_unused  = ^{ir_q[25], ir_q[19:16]};

  // Evaluate a jump condition against the {O,S,C,Z} flag register.
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
    logic o, s, c, z, t;
    {o, s, c, z} = f;
    t = 1'b0;
    case (cond)
      4'd0:    t = 1'b1;
      4'd1:    t = z;
      4'd2:    t = !z;
      4'd3:    t = s;
      4'd4:    t = !s;
      4'd5:    t = c;
      4'd6:    t = !c;
      4'd7:    t = o;
      4'd8:    t = !o;
`ifdef ALU_CTRL_SIGNED_COND_EN
      4'd9:    t = s ^ o;
      4'd10:   t = !(s ^ o);
      4'd11:   t = z | (s ^ o);
      4'd12:   t = !z & !(s ^ o);
`endif
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign jmp_taken = cond_true(ir_q[29:26], flags_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (instr_valid) state_d = S_DECODE;
      S_DECODE: begin
        case (fmt)
          FMT_ALU:  state_d = S_EXEC;
          FMT_LDI:  state_d = S_WB;
          FMT_JMP:  state_d = S_IDLE;
          FMT_HALT: state_d = S_HALT;
          default:  state_d = S_IDLE;
        endcase
      end
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: IR capture, ALU drive, result/flag capture, write-back and PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q         <= '0;
      pc_q         <= RST_PC[PC_W-1:0];
      flags_q      <= '0;
      flags_pend_q <= '0;
      alu_op_q     <= '0;
      rf_ra_q      <= '0;
      rf_rb_q      <= '0;
      rf_wa_q      <= '0;
      rf_wd_q      <= '0;
      rf_we_q      <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            ir_q <= instr;
            if (instr[31:30] == FMT_ALU) begin
              alu_op_q <= instr[29:25];
              rf_ra_q  <= instr[19:15];
              rf_rb_q  <= instr[14:10];
            end
          end
        end
        S_DECODE: begin
          case (fmt)
            FMT_LDI: begin
              rf_we_q <= 1'b1;
              rf_wa_q <= rd;
              rf_wd_q <= imm_sext;
            end
            FMT_JMP:  pc_q     <= jmp_taken ? jmp_target : pc_inc;
            FMT_HALT: halted_q <= 1'b1;
            default: ;
          endcase
        end
        S_EXEC: begin
          rf_we_q      <= 1'b1;
          rf_wa_q      <= rd;
          rf_wd_q      <= alu_res;
          flags_pend_q <= {alu_o, alu_s, alu_c, (alu_res == 32'b0)};
        end
        S_WB: begin
          pc_q <= pc_inc;
          if (fmt == FMT_ALU) flags_q <= flags_pend_q;
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign alu_op      = alu_op_q;
  assign rf_ra       = rf_ra_q;
  assign rf_rb       = rf_rb_q;
  assign rf_wa       = rf_wa_q;
  assign rf_wd       = rf_wd_q;
  assign rf_we       = rf_we_q;
  assign flags       = flags_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed testbench for alu_ctrl_seq. The ALU is a stub whose outputs are
// set per step; expected values are hand-computed constants.
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  alu_op;
  logic [31:0] alu_res;
  logic        alu_o, alu_s, alu_c;
  logic [4:0]  rf_ra, rf_rb, rf_wa;
  logic [31:0] rf_wd;
  logic        rf_we;
  logic [3:0]  flags;
  logic [15:0] pc;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  alu_ctrl_seq #(.PC_W(16), .RST_PC(16'd0)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .alu_op(alu_op), .alu_res(alu_res),
    .alu_o(alu_o), .alu_s(alu_s), .alu_c(alu_c),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we),
    .flags(flags), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_alu(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] ra, input logic [4:0] rb);
    return {2'b00, op, rd, ra, rb, 10'b0};
  endfunction

  function automatic logic [31:0] enc_ldi(input logic [4:0] rd, input logic [15:0] imm);
    return {2'b01, 5'b0, rd, 4'b0, imm};
  endfunction

  function automatic logic [31:0] enc_jmp(input logic [3:0] cond, input logic [15:0] tgt);
    return {2'b10, cond, 10'b0, tgt};
  endfunction

  // Wait (bounded) for ready, hand over one word, return at the DECODE negedge.
  task automatic issue(input logic [31:0] w);
    int n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr       = w;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = $urandom();
  endtask

  // Issue a jump and check the resulting pc and ready at T0+2.
  task automatic do_jmp(input string tag, input logic [3:0] cond, input logic [15:0] tgt,
                        input logic [15:0] exp_pc);
    issue(enc_jmp(cond, tgt));
    check({tag, "_busy"}, instr_ready, 1'b0);
    @(negedge clk);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_ready"}, instr_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    alu_res = '0; alu_o = 1'b0; alu_s = 1'b0; alu_c = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", instr_ready, 1'b1);
    check("rst_pc", pc, 16'h0000);
    check("rst_flags", flags, 4'h0);
    check("rst_we", rf_we, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_op", alu_op, 5'd0);
    check("rst_wd", rf_wd, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Move pc to 5 with an always-taken jump
    do_jmp("jmp_always", 4'd0, 16'h0005, 16'h0005);

    // Reset asserted asynchronously in the middle of EXEC
    alu_res = 32'h0000_1234; alu_c = 1'b1;
    issue(enc_alu(5'd9, 5'd4, 5'd1, 5'd2));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", instr_ready, 1'b1);
    check("arst_pc", pc, 16'h0000);
    check("arst_flags", flags, 4'h0);
    check("arst_we", rf_we, 1'b0);
    check("arst_op", alu_op, 5'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("arst_we_hold", rf_we, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("arst_we_after", rf_we, 1'b0);
    check("arst_flags_after", flags, 4'h0);

    // LDI rd=3 imm=0x8000
    issue(enc_ldi(5'd3, 16'h8000));
    check("ldi_t1_we", rf_we, 1'b0);
    check("ldi_t1_ready", instr_ready, 1'b0);
    @(negedge clk);
    check("ldi_t2_we", rf_we, 1'b1);
    check("ldi_wa", rf_wa, 5'd3);
    check("ldi_wd", rf_wd, 32'hFFFF_8000);
    check("ldi_t2_ready", instr_ready, 1'b0);
    @(negedge clk);
    check("ldi_t3_we", rf_we, 1'b0);
    check("ldi_t3_ready", instr_ready, 1'b1);
    check("ldi_pc", pc, 16'h0001);
    check("ldi_flags", flags, 4'h0);

    // ALU op=5 ra=1 rb=2 rd=7; stub gives res=0, C=1
    alu_res = 32'h0; alu_o = 1'b0; alu_s = 1'b0; alu_c = 1'b1;
    issue(enc_alu(5'b00101, 5'd7, 5'd1, 5'd2));
    check("alu_dec_op", alu_op, 5'b00101);
    check("alu_dec_ra", rf_ra, 5'd1);
    check("alu_dec_rb", rf_rb, 5'd2);
    check("alu_dec_we", rf_we, 1'b0);
    @(negedge clk);
    check("alu_exec_op", alu_op, 5'b00101);
    check("alu_exec_ra", rf_ra, 5'd1);
    check("alu_exec_rb", rf_rb, 5'd2);
    check("alu_exec_we", rf_we, 1'b0);
    @(negedge clk);
    check("alu_wb_we", rf_we, 1'b1);
    check("alu_wb_wa", rf_wa, 5'd7);
    check("alu_wb_wd", rf_wd, 32'h0);
    check("alu_wb_ready", instr_ready, 1'b0);
    @(negedge clk);
    check("alu_t4_ready", instr_ready, 1'b1);
    check("alu_t4_we", rf_we, 1'b0);
    check("alu_flags", flags, 4'b0011);
    check("alu_pc", pc, 16'h0002);
    check("alu_op_hold", alu_op, 5'b00101);
    alu_res = 32'hDEAD_BEEF; alu_c = 1'b0;

    // Conditional jumps against flags {O,S,C,Z} = 0011
    do_jmp("jmp_z", 4'd1, 16'h0040, 16'h0040);
    do_jmp("jmp_nz", 4'd2, 16'h0099, 16'h0041);
    do_jmp("jmp_c13", 4'd13, 16'h0077, 16'h0042);
    do_jmp("jmp_c", 4'd5, 16'h0080, 16'h0080);
    do_jmp("jmp_nc", 4'd6, 16'h0033, 16'h0081);
    do_jmp("jmp_o", 4'd7, 16'h0033, 16'h0082);

    // pc wrap: pc=0xFFFF, LDI with positive imm
    do_jmp("jmp_ffff", 4'd0, 16'hFFFF, 16'hFFFF);
    issue(enc_ldi(5'd0, 16'h1234));
    @(negedge clk);
    check("wrap_ldi_wa", rf_wa, 5'd0);
    check("wrap_ldi_wd", rf_wd, 32'h0000_1234);
    @(negedge clk);
    check("wrap_pc", pc, 16'h0000);
    check("wrap_flags", flags, 4'b0011);

    // Signed condition: flags S=1 O=0 C=0 Z=0
    alu_res = 32'h8000_0000; alu_o = 1'b0; alu_s = 1'b1; alu_c = 1'b0;
    issue(enc_alu(5'd1, 5'd9, 5'd3, 5'd4));
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("sgn_flags", flags, 4'b0100);
    check("sgn_pc", pc, 16'h0001);
`ifdef ALU_CTRL_SIGNED_COND_EN
    do_jmp("jmp_lt", 4'd9, 16'h0010, 16'h0010);
`else
    do_jmp("jmp_lt", 4'd9, 16'h0010, 16'h0002);
`endif
    do_jmp("jmp_s", 4'd3, 16'h0020, 16'h0020);

    // HALT: terminal, ready stays low despite valid
    issue(32'hC000_0000);
    check("halt_t1", halted, 1'b0);
    @(negedge clk);
    check("halt_flag", halted, 1'b1);
    instr_valid = 1'b1;
    instr       = enc_ldi(5'd1, 16'h0001);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_ready", instr_ready, 1'b0);
    end
    check("halt_pc", pc, 16'h0020);
    check("halt_we", rf_we, 1'b0);
    instr_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Multicycle issue/control sequencer that drives the ALU's OP/A/B interface and consumes its RES/O/S/C/Z outputs. It accepts one 32-bit instruction per valid/ready handshake and decodes it into ALU op, register-file addresses and write-back. It holds the architectural flag register, evaluates conditional jumps against it, and maintains the program counter. It sits between instruction fetch and the ALU/register file in the datapath.

Parameters:
PC_W, 16, program counter width; jump target is instr[PC_W-1:0], zero-extended (PC_W <= 16)
RST_PC, 0, PC value loaded on reset

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction present on instr
instr  in  32  instruction word
instr_ready  out  1  sequencer can accept an instruction
alu_op  out  5  OP to ALU
alu_res  in  32  ALU RES
alu_o / alu_s / alu_c  in  1 each  ALU overflow / sign / carry
rf_ra / rf_rb  out  5 each  register-file read addresses (ALU A / B)
rf_wa  out  5  write address
rf_wd  out  32  write data
rf_we  out  1  write enable, one-cycle pulse
flags  out  4  {O,S,C,Z} architectural flags
pc  out  PC_W  program counter
halted  out  1  HALT executed

Behaviour:
- Reset, async, any state: state=IDLE, pc=RST_PC, flags=0, alu_op=0, rf_we=0, rf_wa/rf_ra/rf_rb/rf_wd=0, halted=0. Reset mid-instruction abandons it with no write and no flag update.
- instr_ready = (state==IDLE). Capture occurs on the edge where instr_valid & instr_ready. The word is latched into an internal IR, so instr may change afterwards.
- Format, fmt = IR[31:30]:
  - 00 ALU: op = IR[29:25], rd = IR[24:20], ra = IR[19:15], rb = IR[14:10].
  - 01 LDI: rd = IR[24:20], imm = IR[15:0] sign-extended to 32.
  - 10 JMP: cond = IR[29:26], target = IR[PC_W-1:0].
  - 11 HALT.
- FSM states: IDLE, DECODE, EXEC, WB, HALT.
  - IDLE -> DECODE on handshake.
  - DECODE:
    - ALU: drive rf_ra/rf_rb, alu_op=op; -> EXEC.
    - LDI: -> WB.
    - JMP: if the condition is true, pc <= target, else pc <= pc+1; -> IDLE.
    - HALT: halted <= 1; -> HALT.
  - EXEC: alu_op, rf_ra and rf_rb are held stable. Register res = alu_res and capture alu_o, alu_s, alu_c. Z is computed locally as (alu_res == 32'b0). -> WB.
  - WB: rf_we=1 for exactly this cycle, rf_wa=rd, rf_wd = registered res (ALU) or imm (LDI). For ALU only, flags <= {O,S,C,Z} captured in EXEC; LDI leaves flags unchanged. pc <= pc+1; -> IDLE.
  - HALT: terminal; instr_ready=0; exit only via rst.
- Latency from the handshake edge T0:
  - ALU: rf_we high in cycle T0+3; instr_ready high again at T0+4.
  - LDI: rf_we at T0+2; ready at T0+3.
  - JMP: pc updated at T0+2 edge; ready at T0+2.
- alu_op holds its last value outside EXEC/DECODE.
- A jump following an ALU instruction always sees that instruction's flags, because flags commit in WB before IDLE.
- Conditions, tested against the flags register:
  - 0 always
  - 1 Z
  - 2 !Z
  - 3 S
  - 4 !S
  - 5 C
  - 6 !C
  - 7 O
  - 8 !O
  - 9-15 never taken (pc+1).
- pc wraps modulo 2^PC_W; pc=all-ones with +1 gives 0.
- rd=0 is an ordinary register here; no special casing.

Optional Feature:
- Macro: ALU_CTRL_SIGNED_COND_EN.
- Defined: cond 9 = LT (S^O), 10 = GE !(S^O), 11 = LE (Z|(S^O)), 12 = GT !Z&!(S^O). Codes 13-15 are never taken.
- Undefined: 9-15 are never taken.

Test Plan:
- Reset with pc=0x0005 mid-EXEC, rst asserted async -> within the same cycle: state IDLE, pc=RST_PC, flags=0, rf_we=0, no write ever issued.
- LDI rd=3 imm=0x8000 -> rf_we single pulse at T0+2, rf_wa=3, rf_wd=0xFFFF8000; flags unchanged; pc+1.
- ALU op=00101, ra=1, rb=2, ALU stub returns alu_res=0 and c=1 -> alu_op=5'b00101 during DECODE/EXEC; WB writes 0; flags=4'b0011 (C,Z); ready back at T0+4.
- JMP cond=1 (Z) target=0x0040 after the previous case -> pc=0x0040. Then JMP cond=2 -> pc=0x0041. Cond=13 -> pc+1.
- pc=0xFFFF with PC_W=16, issue LDI -> pc=0x0000. HALT -> halted=1, instr_ready stays 0 for 20 cycles despite instr_valid=1.
- With ALU_CTRL_SIGNED_COND_EN, flags S=1 O=0, JMP cond=9 target 0x10 -> taken. Without the macro, same stimulus -> pc+1.
